ex_mem_reg: RTL



---
 rtl/mips_pkg.sv | 13 +
 rtl/ex_mem_reg_if.sv | 46 ++++
 rtl/ex_mem_reg_pipe_field.sv | 25 ++
 rtl/ex_mem_reg.sv | 64 ++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: datapath width, writeback-source
// encodings and the hardwired zero register index.
package mips_pkg;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      MTR_ALU = 2'b00,
      MTR_MEM = 2'b01,
      MTR_PC4 = 2'b10
   } memtoreg_t;

   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/ex_mem_reg_if.sv
// EX/MEM boundary bundle: EX-side inputs, MEM-side registered outputs and the
// pipeline control strobes. The slave side is the pipeline register itself.
interface ex_mem_reg_if #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int CNT_W  = 16
);
   logic              Stall;
   logic              Flush;
   logic              RegWr_ID_EX;
   logic              MemWr_ID_EX;
   logic              MemRd_ID_EX;
   logic [1:0]        MemtoReg_ID_EX;
   logic [DATA_W-1:0] ALUOut_EX;
   logic [DATA_W-1:0] DataB_EX;
   logic [DATA_W-1:0] PCplus4_ID_EX;
   logic [4:0]        RegisterRd_EX;
   logic [4:0]        RegisterRt_ID_EX;

   logic              RegWr_EX_MEM;
   logic              MemWr_EX_MEM;
   logic              MemRd_EX_MEM;
   logic [1:0]        MemtoReg_EX_MEM;
   logic [DATA_W-1:0] ALUOut_EX_MEM;
   logic [DATA_W-1:0] DataB_EX_MEM;
   logic [DATA_W-1:0] PCplus4_EX_MEM;
   logic [4:0]        RegisterRd_EX_MEM;
   logic [4:0]        RegisterRt_EX_MEM;
   logic              Valid_EX_MEM;
   logic [CNT_W-1:0]  BubbleCnt;

   modport master (
      output Stall, Flush, RegWr_ID_EX, MemWr_ID_EX, MemRd_ID_EX, MemtoReg_ID_EX,
             ALUOut_EX, DataB_EX, PCplus4_ID_EX, RegisterRd_EX, RegisterRt_ID_EX,
      input  RegWr_EX_MEM, MemWr_EX_MEM, MemRd_EX_MEM, MemtoReg_EX_MEM,
             ALUOut_EX_MEM, DataB_EX_MEM, PCplus4_EX_MEM, RegisterRd_EX_MEM,
             RegisterRt_EX_MEM, Valid_EX_MEM, BubbleCnt
   );

   modport slave (
      input  Stall, Flush, RegWr_ID_EX, MemWr_ID_EX, MemRd_ID_EX, MemtoReg_ID_EX,
             ALUOut_EX, DataB_EX, PCplus4_ID_EX, RegisterRd_EX, RegisterRt_ID_EX,
      output RegWr_EX_MEM, MemWr_EX_MEM, MemRd_EX_MEM, MemtoReg_EX_MEM,
             ALUOut_EX_MEM, DataB_EX_MEM, PCplus4_EX_MEM, RegisterRd_EX_MEM,
             RegisterRt_EX_MEM, Valid_EX_MEM, BubbleCnt
   );
endinterface

// File: rtl/ex_mem_reg_pipe_field.sv
// One pipeline field: W-bit flop with synchronous active-low reset,
// clear-to-zero (bubble) taking priority over hold (stall).
module pipe_field #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         hold,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] q_reg;

   always_ff @(posedge clk) begin
      if (!reset)
         q_reg <= '0;
      else if (clear)
         q_reg <= '0;
      else if (!hold)
         q_reg <= d;
   end

   assign q = q_reg;
endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall, flush-to-bubble and a saturating
// bubble counter for performance debug.
module ex_mem_reg
   import mips_pkg::*;
#(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int CNT_W  = 16
) (
   input logic         clk,
   input logic         reset,
   ex_mem_reg_if.slave bus
);
   logic [CNT_W-1:0] bubble_cnt_reg;

   pipe_field #(.W(1)) u_regwr (
      .clk(clk), .reset(reset), .hold(bus.Stall), .clear(bus.Flush),
      .d(bus.RegWr_ID_EX), .q(bus.RegWr_EX_MEM));

   pipe_field #(.W(1)) u_memwr (
      .clk(clk), .reset(reset), .hold(bus.Stall), .clear(bus.Flush),
      .d(bus.MemWr_ID_EX), .q(bus.MemWr_EX_MEM));

   pipe_field #(.W(1)) u_memrd (
      .clk(clk), .reset(reset), .hold(bus.Stall), .clear(bus.Flush),
      .d(bus.MemRd_ID_EX), .q(bus.MemRd_EX_MEM));

   pipe_field #(.W(2)) u_memtoreg (
      .clk(clk), .reset(reset), .hold(bus.Stall), .clear(bus.Flush),
      .d(bus.MemtoReg_ID_EX), .q(bus.MemtoReg_EX_MEM));

   pipe_field #(.W(DATA_W)) u_aluout (
      .clk(clk), .reset(reset), .hold(bus.Stall), .clear(bus.Flush),
      .d(bus.ALUOut_EX), .q(bus.ALUOut_EX_MEM));

   pipe_field #(.W(DATA_W)) u_datab (
      .clk(clk), .reset(reset), .hold(bus.Stall), .clear(bus.Flush),
      .d(bus.DataB_EX), .q(bus.DataB_EX_MEM));

   pipe_field #(.W(DATA_W)) u_pcplus4 (
      .clk(clk), .reset(reset), .hold(bus.Stall), .clear(bus.Flush),
      .d(bus.PCplus4_ID_EX), .q(bus.PCplus4_EX_MEM));

   // Writes to $0 pass through unfiltered; forwarding already ignores them.
   pipe_field #(.W(5)) u_rd (
      .clk(clk), .reset(reset), .hold(bus.Stall), .clear(bus.Flush),
      .d(bus.RegisterRd_EX), .q(bus.RegisterRd_EX_MEM));

   pipe_field #(.W(5)) u_rt (
      .clk(clk), .reset(reset), .hold(bus.Stall), .clear(bus.Flush),
      .d(bus.RegisterRt_ID_EX), .q(bus.RegisterRt_EX_MEM));

   pipe_field #(.W(1)) u_valid (
      .clk(clk), .reset(reset), .hold(bus.Stall), .clear(bus.Flush),
      .d(1'b1), .q(bus.Valid_EX_MEM));

   always_ff @(posedge clk) begin
      if (!reset)
         bubble_cnt_reg <= '0;
      else if (bus.Flush && (bubble_cnt_reg != {CNT_W{1'b1}}))
         bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
   end

   assign bus.BubbleCnt = bubble_cnt_reg;
endmodule
